shifter_pipe: RTL and testbench

Parametrised, pipelined barrel shifter for the datapath execute stage. It succeeds the fixed 16-bit combinational arithmetic-right shifter. It adds configurable width, five shift/rotate modes, one register stage per shift-amount bit, and a valid/ready handshake with backpressure, so that wide shifts do not set the cycle time.

---
 rtl/shifter_pipe.sv | 114 +++++++++++
 tb/tb_shifter_pipe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, five shift/rotate
// modes, valid/ready handshake with whole-pipeline backpressure.
module shifter_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In,
    input  logic [SHW-1:0]   ShAmt,
    input  logic [2:0]       Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             OpErr
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    function automatic logic is_reserved(input logic [2:0] op);
        is_reserved = (op > OP_ROR);
    endfunction

    // One stage's worth of work: move by 2^k when enabled; reserved ops pass through.
    function automatic logic signed [WIDTH-1:0] stage_shift(
        input logic signed [WIDTH-1:0] d,
        input int                      k,
        input logic                    en,
        input logic [2:0]              op
    );
        logic [WIDTH-1:0] u;
        int               n;
        u = d;
        n = 1 << k;
        stage_shift = d;
        if (en) begin
            case (op)
                OP_SLL:  stage_shift = u << n;
                OP_SRL:  stage_shift = u >> n;
                OP_SRA:  stage_shift = d >>> n;
                OP_ROL:  stage_shift = (u << n) | (u >> (WIDTH - n));
                OP_ROR:  stage_shift = (u >> n) | (u << (WIDTH - n));
                default: stage_shift = d;
            endcase
        end
    endfunction

    logic                    vld_p  [SHW];
    logic signed [WIDTH-1:0] data_p [SHW];
    logic [SHW-1:0]          amt_p  [SHW];
    logic [2:0]              op_p   [SHW];
    logic                    err_p  [SHW];

    logic                    vld_nxt  [SHW];
    logic signed [WIDTH-1:0] data_nxt [SHW];
    logic [SHW-1:0]          amt_nxt  [SHW];
    logic [2:0]              op_nxt   [SHW];
    logic                    err_nxt  [SHW];

    logic stall;

    assign stall    = vld_p[SHW-1] && !out_ready;
    assign in_ready = !stall;

    // Stage inputs; amt is shifted down each stage so bit 0 is always the one in play.
    always_comb begin
        vld_nxt[0]  = in_valid && in_ready;
        data_nxt[0] = stage_shift(In, 0, ShAmt[0], Op);
        amt_nxt[0]  = ShAmt >> 1;
        op_nxt[0]   = Op;
        err_nxt[0]  = is_reserved(Op);
        for (int k = 1; k < SHW; k++) begin
            vld_nxt[k]  = vld_p[k-1];
            data_nxt[k] = stage_shift(data_p[k-1], k, amt_p[k-1][0], op_p[k-1]);
            amt_nxt[k]  = amt_p[k-1] >> 1;
            op_nxt[k]   = op_p[k-1];
            err_nxt[k]  = err_p[k-1];
        end
    end

    // Stage registers p0..p(SHW-1): all advance together or all hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SHW; k++) begin
                vld_p[k]  <= 1'b0;
                data_p[k] <= '0;
                amt_p[k]  <= '0;
                op_p[k]   <= '0;
                err_p[k]  <= 1'b0;
            end
        end else if (!stall) begin
            for (int k = 0; k < SHW; k++) begin
                vld_p[k]  <= vld_nxt[k];
                data_p[k] <= data_nxt[k];
                amt_p[k]  <= amt_nxt[k];
                op_p[k]   <= op_nxt[k];
                err_p[k]  <= err_nxt[k];
            end
        end
    end

    assign out_valid = vld_p[SHW-1];
    assign Out       = data_p[SHW-1];
    assign Zero      = (data_p[SHW-1] == '0);
    assign OpErr     = err_p[SHW-1];

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed self-checking bench for shifter_pipe at WIDTH=16 and WIDTH=32.
module tb_shifter_pipe;

    logic        clk;
    logic        rst;

    logic        iv16, ir16, ov16, or16, z16, e16;
    logic [15:0] in16, out16;
    logic [3:0]  amt16;
    logic [2:0]  op16;

    logic        iv32, ir32, ov32, or32, z32, e32;
    logic [31:0] in32, out32;
    logic [4:0]  amt32;
    logic [2:0]  op32;

    int n_cmp = 0;
    int n_err = 0;

    shifter_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .In(in16),
        .ShAmt(amt16), .Op(op16), .out_valid(ov16), .out_ready(or16),
        .Out(out16), .Zero(z16), .OpErr(e16)
    );

    shifter_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .In(in32),
        .ShAmt(amt32), .Op(op32), .out_valid(ov32), .out_ready(or32),
        .Out(out32), .Zero(z32), .OpErr(e32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish, required finish before 500000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Single beat through the 16-bit pipe; result due 4 cycles after presentation.
    task automatic run16(input string tag, input logic [15:0] d, input logic [3:0] a,
                         input logic [2:0] o, input logic [15:0] e, input logic ez,
                         input logic ee);
        @(negedge clk);
        in16 = d; amt16 = a; op16 = o; iv16 = 1'b1; or16 = 1'b1;
        @(negedge clk);
        iv16 = 1'b0; in16 = '0;
        chk({tag, "_early0"}, ov16, 0);
        repeat (2) @(negedge clk);
        chk({tag, "_early2"}, ov16, 0);
        @(negedge clk);
        chk({tag, "_valid"}, ov16, 1);
        chk({tag, "_out"}, out16, e);
        chk({tag, "_zero"}, z16, ez);
        chk({tag, "_operr"}, e16, ee);
    endtask

    task automatic run32(input string tag, input logic [31:0] d, input logic [4:0] a,
                         input logic [2:0] o, input logic [31:0] e);
        @(negedge clk);
        in32 = d; amt32 = a; op32 = o; iv32 = 1'b1; or32 = 1'b1;
        @(negedge clk);
        iv32 = 1'b0; in32 = '0;
        repeat (3) @(negedge clk);
        chk({tag, "_early"}, ov32, 0);
        @(negedge clk);
        chk({tag, "_valid"}, ov32, 1);
        chk({tag, "_out"}, out32, e);
        chk({tag, "_operr"}, e32, 0);
    endtask

    function automatic logic [15:0] bp_in(input int i);
        bp_in = 16'(i + 1) * 16'h0101;
    endfunction

    initial begin
        int          sent, recv, cyc;
        logic        held_v;
        logic [15:0] held;
        bit          pat[4];

        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst = 1'b1;
        iv16 = 0; in16 = '0; amt16 = '0; op16 = '0; or16 = 0;
        iv32 = 0; in32 = '0; amt32 = '0; op32 = '0; or32 = 0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ov", ov16, 0);
        chk("rst_out", out16, 16'h0000);
        chk("rst_zero", z16, 1);
        chk("rst_operr", e16, 0);
        chk("rst_inready", ir16, 1);
        chk("rst_ov32", ov32, 0);
        rst = 1'b0;

        // Single beat and all modes
        run16("sra_first", 16'h8001, 4'd1, 3'b010, 16'hC000, 1'b0, 1'b0);
        run16("sll4", 16'h8421, 4'd4, 3'b000, 16'h4210, 1'b0, 1'b0);
        run16("srl4", 16'h8421, 4'd4, 3'b001, 16'h0842, 1'b0, 1'b0);
        run16("sra4", 16'h8421, 4'd4, 3'b010, 16'hF842, 1'b0, 1'b0);
        run16("rol4", 16'h8421, 4'd4, 3'b011, 16'h4218, 1'b0, 1'b0);
        run16("ror4", 16'h8421, 4'd4, 3'b100, 16'h1842, 1'b0, 1'b0);

        // Boundaries
        run16("sll15", 16'hFFFF, 4'd15, 3'b000, 16'h8000, 1'b0, 1'b0);
        run16("srl15", 16'hFFFF, 4'd15, 3'b001, 16'h0001, 1'b0, 1'b0);
        run16("sra15", 16'hFFFF, 4'd15, 3'b010, 16'hFFFF, 1'b0, 1'b0);
        run16("ror0", 16'hFFFF, 4'd0, 3'b100, 16'hFFFF, 1'b0, 1'b0);
        run16("srl_zero", 16'h0001, 4'd1, 3'b001, 16'h0000, 1'b1, 1'b0);
        run16("rol9", 16'h00F1, 4'd9, 3'b011, 16'hE201, 1'b0, 1'b0);

        // Reserved op
        run16("resv", 16'h1234, 4'd3, 3'b110, 16'h1234, 1'b0, 1'b1);

        // Backpressure stream: 8 beats of SLL by 1 under out_ready pattern 1,0,0,1
        sent = 0; recv = 0; cyc = 0; held_v = 1'b0; held = '0;
        while (recv < 8 && cyc < 100) begin
            @(negedge clk);
            iv16 = (sent < 8);
            in16 = bp_in(sent);
            amt16 = 4'd1; op16 = 3'b000;
            or16 = pat[cyc % 4];
            #1;
            if (held_v) chk("bp_hold", {ov16, out16}, {1'b1, held});
            if (ov16) chk("bp_ready", ir16, or16);
            held_v = ov16 && !or16;
            held = out16;
            if (ov16 && or16) begin
                chk("bp_data", out16, bp_in(recv) << 1);
                recv++;
            end
            if (iv16 && ir16) sent++;
            cyc++;
        end
        chk("bp_count", recv, 8);
        @(negedge clk);
        iv16 = 1'b0; or16 = 1'b1;
        #1;
        chk("bp_drained", ov16, 0);

        // Reset with three beats in flight
        @(negedge clk);
        in16 = 16'h0F0F; amt16 = 4'd2; op16 = 3'b011; iv16 = 1'b1; or16 = 1'b1;
        @(negedge clk);
        in16 = 16'h1111;
        @(negedge clk);
        in16 = 16'h2222;
        @(negedge clk);
        iv16 = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_during", ov16, 0);
        @(negedge clk);
        chk("mid_rst_held", ov16, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_rst_after", ov16, 0);
        end

        // 32-bit instance
        run32("w32_sra31", 32'h8000_0000, 5'd31, 3'b010, 32'hFFFF_FFFF);
        run32("w32_sll31", 32'h0000_0001, 5'd31, 3'b000, 32'h8000_0000);
        run32("w32_srl31", 32'h8000_0000, 5'd31, 3'b001, 32'h0000_0001);
        run32("w32_rol4", 32'h8000_0001, 5'd4, 3'b011, 32'h0000_0018);
        run32("w32_ror1", 32'h0000_0001, 5'd1, 3'b100, 32'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
